// File: rtl/uart_rx_fsm_pkg.sv
// UART shared definitions: frame controller state encoding,
// legal oversampling ratios and the end-of-bit edge helper.
package uart_rx_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        CHECK  = 3'd5
    } uart_state_t;

    localparam logic [5:0] PRE_8   = 6'd8;
    localparam logic [5:0] PRE_16  = 6'd16;
    localparam logic [5:0] PRE_32  = 6'd32;
    localparam logic [5:0] PRE_MIN = 6'd4;

    // Last edge index of a bit; ratios below 4 are clamped to 4.
    function automatic logic [5:0] eob_edge(input logic [5:0] pre);
        return (pre < PRE_MIN) ? PRE_MIN - 6'd1 : pre - 6'd1;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Edge/bit counter for the UART receiver frame controller.
// Ports: CLK, RST, enable, Prescale_q in; edge_count, bit_count, eob out.
module uart_rx_edge_bit_cnt
    import uart_rx_fsm_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    input  logic [5:0] Prescale_q,
    output logic [5:0] edge_count,
    output logic [3:0] bit_count,
    output logic       eob
);

    assign eob = enable && (edge_count == eob_edge(Prescale_q));

    // Counters sit at zero whenever disabled, so every frame
    // starts from edge 0 / bit 0 on its first START cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (!enable) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (eob) begin
            edge_count <= '0;
            bit_count  <= bit_count + 4'd1;
        end else begin
            edge_count <= edge_count + 6'd1;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detect, data strobes,
// parity/stop checks and the data_valid pulse.
// Ports: CLK, RST, RX_IN, sampled_bit, PAR_EN, PAR_TYP, Prescale in;
//        edge_count, bit_count, sample_en, deser_en, data_valid,
//        par_err, stp_err out.
module uart_rx_fsm
    import uart_rx_fsm_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       sampled_bit,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [5:0] Prescale,
    output logic [5:0] edge_count,
    output logic [3:0] bit_count,
    output logic       sample_en,
    output logic       deser_en,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);

    uart_state_t state, state_d;
    logic        par_en_q, par_typ_q;
    logic [5:0]  prescale_q;
    logic        acc, acc_d;
    logic        par_err_d, stp_err_d;
    logic        cap;
    logic        cnt_en, eob;

    assign cnt_en    = state inside {START, DATA, PARITY, STOP};
    assign sample_en = (state != IDLE);

    uart_rx_edge_bit_cnt u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .enable     (cnt_en),
        .Prescale_q (prescale_q),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .eob        (eob)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            prescale_q <= PRE_8;
            acc        <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            par_err <= par_err_d;
            stp_err <= stp_err_d;
            if (cap) begin
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                prescale_q <= Prescale;
            end
        end
    end

    always_comb begin
        state_d    = state;
        acc_d      = acc;
        par_err_d  = par_err;
        stp_err_d  = stp_err;
        cap        = 1'b0;
        deser_en   = 1'b0;
        data_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_d = START;
                    cap     = 1'b1;
                end
            end
            START: begin
                if (eob) state_d = sampled_bit ? IDLE : DATA;
            end
            DATA: begin
                if (eob) begin
                    deser_en = 1'b1;
                    acc_d    = acc ^ sampled_bit;
                    if (bit_count == LAST_BIT)
                        state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (eob) begin
                    par_err_d = sampled_bit ^ acc ^ par_typ_q;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (eob) begin
                    stp_err_d = ~sampled_bit;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                data_valid = ~(par_err | stp_err);
                if (!RX_IN) begin
                    state_d = START;
                    cap     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new frame starts with fresh error flags and parity.
        if (cap) begin
            acc_d     = 1'b0;
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: line driver, deserializer model and
// spec-level expectations for frame timing, errors and data.
module tb_uart_rx_fsm;
    import uart_rx_fsm_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic       sampled_bit = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic       sample_en, deser_en, data_valid, par_err, stp_err;

    int checks = 0;
    int errors = 0;

    int         sen_cnt = 0;
    int         deser_cnt = 0;
    int         dv_cnt = 0;
    logic [7:0] p_data = '0;
    logic [7:0] rx_q[$];

    uart_rx_fsm #(.DATA_WIDTH(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .sampled_bit (sampled_bit),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .Prescale    (Prescale),
        .edge_count  (edge_count),
        .bit_count   (bit_count),
        .sample_en   (sample_en),
        .deser_en    (deser_en),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    always #5 CLK = ~CLK;

    // Downstream deserializer model (LSB first) plus event counters.
    always @(negedge CLK) begin
        if (sample_en) sen_cnt++;
        if (deser_en) begin
            deser_cnt++;
            p_data = {sampled_bit, p_data[7:1]};
        end
        if (data_valid) begin
            dv_cnt++;
            rx_q.push_back(p_data);
        end
    end

    task automatic drive_bit(input logic v, input int n);
        #1;
        RX_IN = v;
        sampled_bit = v;
        repeat (n) @(posedge CLK);
    endtask

    // Called at a posedge; returns at the posedge of the stop-bit decision.
    task automatic send_frame(input logic [7:0] d, input int p,
                              input bit pe, input bit pt, input bit flip,
                              input bit stop_v, input bit scr);
        #1;
        PAR_EN = pe;
        PAR_TYP = pt;
        Prescale = 6'(p);
        RX_IN = 1'b0;
        sampled_bit = 1'b0;
        @(posedge CLK);
        #1;
        if (scr) begin
            PAR_EN = 1'($urandom);
            PAR_TYP = 1'($urandom);
            Prescale = 6'($urandom_range(4, 40));
        end
        repeat (p) @(posedge CLK);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pe) drive_bit((^d) ^ pt ^ flip, p);
        drive_bit(stop_v, p);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({edge_count, bit_count, sample_en, deser_en, data_valid,
             par_err, stp_err} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {edge_count, bit_count, sample_en, deser_en,
                      data_valid, par_err, stp_err});
        end
        @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (sample_en !== 1'b0 || edge_count !== 6'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got sen=%b edge=%0d expected 0 0",
                     sample_en, edge_count);
        end
        @(posedge CLK);
    endtask

    task automatic test_single_frame(input string nm, input logic [7:0] d,
                                     input int p, input bit pe, input bit pt,
                                     input bit flip, input bit stop_v,
                                     input bit scr);
        int  b_de, b_dv, b_sen, b_q, len;
        bit  e_par, e_stp, e_v;
        b_de  = deser_cnt;
        b_dv  = dv_cnt;
        b_sen = sen_cnt;
        b_q   = rx_q.size();
        e_par = pe & flip;
        e_stp = ~stop_v;
        e_v   = !(e_par || e_stp);
        len   = (10 + int'(pe)) * p + 1;
        send_frame(d, p, pe, pt, flip, stop_v, scr);
        #1;
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
        @(negedge CLK);
        checks++;
        if (data_valid !== e_v) begin
            errors++;
            $display("FAIL %s data_valid: got %b expected %b", nm, data_valid, e_v);
        end
        checks++;
        if (par_err !== e_par || stp_err !== e_stp) begin
            errors++;
            $display("FAIL %s errs: got par=%b stp=%b expected par=%b stp=%b",
                     nm, par_err, stp_err, e_par, e_stp);
        end
        checks++;
        if (bit_count !== 4'(10 + int'(pe)) || edge_count !== 6'd0) begin
            errors++;
            $display("FAIL %s check_counts: got bit=%0d edge=%0d expected bit=%0d edge=0",
                     nm, bit_count, edge_count, 10 + int'(pe));
        end
        @(posedge CLK);
        drive_bit(1'b1, 3);
        @(negedge CLK);
        checks++;
        if (deser_cnt - b_de != 8) begin
            errors++;
            $display("FAIL %s deser_count: got %0d expected 8", nm, deser_cnt - b_de);
        end
        checks++;
        if (dv_cnt - b_dv != int'(e_v)) begin
            errors++;
            $display("FAIL %s dv_count: got %0d expected %0d", nm, dv_cnt - b_dv, e_v);
        end
        checks++;
        if (sen_cnt - b_sen != len) begin
            errors++;
            $display("FAIL %s frame_len: got %0d expected %0d", nm, sen_cnt - b_sen, len);
        end
        checks++;
        if (par_err !== e_par || stp_err !== e_stp || sample_en !== 1'b0) begin
            errors++;
            $display("FAIL %s held_errs: got par=%b stp=%b sen=%b expected %b %b 0",
                     nm, par_err, stp_err, sample_en, e_par, e_stp);
        end
        if (e_v) begin
            checks++;
            if (rx_q.size() != b_q + 1) begin
                errors++;
                $display("FAIL %s rx_count: got %0d expected %0d", nm, rx_q.size(), b_q + 1);
            end else if (rx_q[b_q] !== d) begin
                errors++;
                $display("FAIL %s p_data: got %h expected %h", nm, rx_q[b_q], d);
            end
        end
        @(posedge CLK);
    endtask

    task automatic test_glitch();
        int b_de, b_dv, b_sen;
        b_de  = deser_cnt;
        b_dv  = dv_cnt;
        b_sen = sen_cnt;
        #1;
        PAR_EN = 1'b0;
        Prescale = PRE_8;
        RX_IN = 1'b0;
        sampled_bit = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RX_IN = 1'b1;
        repeat (12) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (sen_cnt - b_sen != 8 || sample_en !== 1'b0) begin
            errors++;
            $display("FAIL glitch_start_len: got %0d sen=%b expected 8 0",
                     sen_cnt - b_sen, sample_en);
        end
        checks++;
        if (deser_cnt != b_de || dv_cnt != b_dv) begin
            errors++;
            $display("FAIL glitch_strobes: got de=%0d dv=%0d expected 0 0",
                     deser_cnt - b_de, dv_cnt - b_dv);
        end
        @(posedge CLK);
    endtask

    task automatic test_back_to_back();
        int b_de, b_dv, b_sen, b_q;
        b_de  = deser_cnt;
        b_dv  = dv_cnt;
        b_sen = sen_cnt;
        b_q   = rx_q.size();
        send_frame(8'h55, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
        @(posedge CLK);
        drive_bit(1'b1, 3);
        @(negedge CLK);
        checks++;
        if (dv_cnt - b_dv != 2 || deser_cnt - b_de != 16) begin
            errors++;
            $display("FAIL b2b_counts: got dv=%0d de=%0d expected 2 16",
                     dv_cnt - b_dv, deser_cnt - b_de);
        end
        checks++;
        if (sen_cnt - b_sen != 2 * (11 * 32 + 1)) begin
            errors++;
            $display("FAIL b2b_len: got %0d expected %0d",
                     sen_cnt - b_sen, 2 * (11 * 32 + 1));
        end
        checks++;
        if (rx_q.size() != b_q + 2) begin
            errors++;
            $display("FAIL b2b_rx_count: got %0d expected %0d", rx_q.size(), b_q + 2);
        end else if (rx_q[b_q] !== 8'h55 || rx_q[b_q + 1] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_data: got %h %h expected 55 ff",
                     rx_q[b_q], rx_q[b_q + 1]);
        end
        @(posedge CLK);
    endtask

    task automatic test_mid_reset();
        int         b_de, b_dv;
        logic [7:0] d;
        d    = 8'hF0;
        b_de = deser_cnt;
        b_dv = dv_cnt;
        #1;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        Prescale = PRE_8;
        RX_IN = 1'b0;
        sampled_bit = 1'b0;
        repeat (9) @(posedge CLK);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 8);
        drive_bit(d[3], 3);
        @(negedge CLK);
        checks++;
        if (bit_count !== 4'd4 || deser_cnt - b_de != 3) begin
            errors++;
            $display("FAIL rst_pre_state: got bit=%0d de=%0d expected 4 3",
                     bit_count, deser_cnt - b_de);
        end
        RST = 1'b1;
        #1;
        checks++;
        if ({edge_count, bit_count, sample_en, deser_en, data_valid,
             par_err, stp_err} !== 15'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h expected 0",
                     {edge_count, bit_count, sample_en, deser_en,
                      data_valid, par_err, stp_err});
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
        @(posedge CLK);
        drive_bit(1'b1, 20);
        @(negedge CLK);
        checks++;
        if (dv_cnt != b_dv || sample_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard: got dv=%0d sen=%b expected 0 0",
                     dv_cnt - b_dv, sample_en);
        end
        @(posedge CLK);
        test_single_frame("rst_clean", 8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [5:0] pres[3];
        pres[0] = PRE_8;
        pres[1] = PRE_16;
        pres[2] = PRE_32;
        for (int n = 0; n < 24; n++) begin
            test_single_frame("rand", 8'($urandom),
                              int'(pres[$urandom_range(0, 2)]),
                              1'($urandom), 1'($urandom),
                              ($urandom_range(0, 5) == 0),
                              ($urandom_range(0, 5) != 0), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame("a5_even", 8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        test_single_frame("a5_parbad", 8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        test_single_frame("3c_stpbad", 8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_single_frame("both_bad", 8'h0F, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        test_glitch();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
